// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The checksum trailer is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = 16;
    localparam int CSUM_W     = 32;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam int SHIFT_W    = 8 * (WORD_BYTES - 1);

    // Byte address of word idx; the word count is bounded well below 2**62.
    function automatic logic [63:0] word_addr(input logic [63:0]        base,
                                              input logic [COUNT_W-1:0] idx);
        return base + {46'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from four accepted bytes.
// The word is presented combinationally together with the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [7:0]          i_data,
    output logic [CSUM_W-1:0]   o_word,
    output logic                o_word_valid
);

    logic [LANE_W-1:0]  r_lane;
    logic [SHIFT_W-1:0] r_shift;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_valid) begin
            r_lane  <= r_lane + 1'b1;
            r_shift <= {i_data, r_shift[SHIFT_W-1:8]};
        end
    end

    assign o_word       = {i_data, r_shift};
    assign o_word_valid = i_valid && (r_lane == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> instruction memory, then cpu enable.
// Define LOADER_CHECKSUM_EN to require a 32-bit sum trailer after the data words.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          MAX_WORDS = 512
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    input  logic                i_start,
    input  logic                i_s_valid,
    input  logic [7:0]          i_s_data,
    output logic                o_s_ready,
    output logic [63:0]         o_addr_ext,
    output logic                o_wen_ext,
    output logic                o_ren_ext,
    output logic [31:0]         o_wdata_ext,
    output logic                o_cpu_enable,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [COUNT_W-1:0]  o_words_loaded
);

    localparam logic [COUNT_W-1:0] MAX_N = COUNT_W'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t EMPTY_NEXT = S_CSUM;
    localparam state_t LAST_NEXT  = S_CSUM;
`else
    localparam state_t EMPTY_NEXT = S_DONE;
    localparam state_t LAST_NEXT  = S_DONE;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_hdr_lo;
    logic [COUNT_W-1:0] r_count_n;
    logic [COUNT_W-1:0] r_words_loaded;
    logic [63:0]        r_addr;
    logic [31:0]        r_wdata;

    logic               w_xfer;
    logic               w_start_go;
    logic               w_pack_valid;
    logic               w_word_valid;
    logic               w_last_word;
    logic [CSUM_W-1:0]  w_word;
    logic [COUNT_W-1:0] w_hdr_n;

    assign o_s_ready    = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                          (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer       = i_s_valid && o_s_ready;
    assign w_start_go   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                      (r_state == S_ERR));
    assign w_hdr_n      = {i_s_data, r_hdr_lo};
    assign w_last_word  = (r_words_loaded + 16'd1) == r_count_n;
    assign w_pack_valid = w_xfer && ((r_state == S_DATA) || (r_state == S_CSUM));

    // Header bytes bypass the packer, so data and trailer both start on lane 0.
    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_clear      (w_start_go),
        .i_valid      (w_pack_valid),
        .i_data       (i_s_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] r_csum;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_csum <= '0;
        end else if (w_start_go) begin
            r_csum <= '0;
        end else if (r_state == S_WRITE) begin
            r_csum <= r_csum + r_wdata;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_go) begin
                    w_state_next = S_HDR0;
                end
            end
            S_HDR0: begin
                if (i_s_valid) begin
                    w_state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (i_s_valid) begin
                    if (w_hdr_n == '0) begin
                        w_state_next = EMPTY_NEXT;
                    end else if (w_hdr_n > MAX_N) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_valid) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = w_last_word ? LAST_NEXT : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_word_valid) begin
                    w_state_next = (w_word == r_csum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_hdr_lo       <= '0;
            r_count_n      <= '0;
            r_words_loaded <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
        end else begin
            if (w_start_go) begin
                r_count_n      <= '0;
                r_words_loaded <= '0;
            end
            if ((r_state == S_HDR0) && w_xfer) begin
                r_hdr_lo <= i_s_data;
            end
            if ((r_state == S_HDR1) && w_xfer) begin
                r_count_n <= w_hdr_n;
            end
            // Address and data are captured with the 4th byte so WRITE only strobes.
            if ((r_state == S_DATA) && w_word_valid) begin
                r_addr  <= word_addr(BASE_ADDR, r_words_loaded);
                r_wdata <= w_word;
            end
            if (r_state == S_WRITE) begin
                r_words_loaded <= r_words_loaded + 16'd1;
            end
        end
    end

    assign o_addr_ext     = r_addr;
    assign o_wdata_ext    = r_wdata;
    assign o_wen_ext      = (r_state == S_WRITE);
    assign o_ren_ext      = 1'b0;
    assign o_cpu_enable   = (r_state == S_DONE);
    assign o_done         = (r_state == S_DONE);
    assign o_error        = (r_state == S_ERR);
    assign o_busy         = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA) ||
                            (r_state == S_WRITE) || (r_state == S_CSUM);
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus randomized handshake gaps.
// Expected writes are derived from the byte stream itself (header count, byte positions).
module tb_imem_loader;
    import loader_pkg::*;

    localparam logic [63:0] BASE = 64'h0;
    localparam int          MAXW = 512;
    localparam int          BOUND = 4000;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .i_clk          (clk),
        .i_arst_n       (arst_n),
        .i_start        (start),
        .i_s_valid      (s_valid),
        .i_s_data       (s_data),
        .o_s_ready      (s_ready),
        .o_addr_ext     (addr_ext),
        .o_wen_ext      (wen_ext),
        .o_ren_ext      (ren_ext),
        .o_wdata_ext    (wdata_ext),
        .o_cpu_enable   (cpu_enable),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t make_image(input wq_t words);
        bq_t b;
        int  n = words.size();
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        foreach (words[i])
            for (int k = 0; k < 4; k++) b.push_back(8'(words[i] >> (8 * k)));
        return b;
    endfunction

`ifdef LOADER_CHECKSUM_EN
    function automatic bq_t with_trailer(input bq_t img, input wq_t words, input logic [31:0] delta);
        bq_t         b = img;
        logic [31:0] sum = delta;
        foreach (words[i]) sum += words[i];
        for (int k = 0; k < 4; k++) b.push_back(8'(sum >> (8 * k)));
        return b;
    endfunction
`endif

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_addr"}, addr_ext, 0);
        chk({tag, "_wen"}, wen_ext, 0);
        chk({tag, "_ren"}, ren_ext, 0);
        chk({tag, "_wdata"}, wdata_ext, 0);
        chk({tag, "_cpu_en"}, cpu_enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random valid
    task automatic send(input bq_t b, input int first, input int last, input int mode,
                        input string tag);
        int  idx = first;
        int  cyc = 0;
        int  n = {b[1], b[0]};
        bit  tog = 1'b0;
        bit  v;
        bit  xfer;
        bit  want_wen;
        logic [63:0] e_addr = '0;
        logic [31:0] e_data = '0;
        while (idx < last && cyc < BOUND) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tog     = !tog;
            s_valid = v;
            s_data  = v ? b[idx] : 8'($urandom);
            xfer    = v && s_ready;
            @(posedge clk);
            #1;
            want_wen = 1'b0;
            if (xfer) begin
                int p = idx - 2;
                if (idx >= 2 && n <= MAXW && p < 4 * n && (p % 4) == 3) begin
                    want_wen = 1'b1;
                    e_addr   = BASE + 64'(4 * (p / 4));
                    e_data   = {b[idx], b[idx-1], b[idx-2], b[idx-3]};
                end
                idx++;
            end
            chk({tag, "_wen"}, wen_ext, want_wen);
            if (want_wen) begin
                chk({tag, "_addr"}, addr_ext, e_addr);
                chk({tag, "_wdata"}, wdata_ext, e_data);
                chk({tag, "_ready_in_write"}, s_ready, 0);
            end
            cyc++;
        end
        s_valid = 1'b0;
        chk({tag, "_stream_bound"}, cyc < BOUND, 1);
    endtask

    task automatic wait_end(input string tag, input bit exp_done, input int exp_words);
        int cyc = 0;
        while (!(done || error) && cyc < 50) begin
            @(posedge clk);
            #1;
            chk({tag, "_tail_wen"}, wen_ext, 0);
            cyc++;
        end
        chk({tag, "_end_bound"}, done || error, 1);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_cpu_en"}, cpu_enable, exp_done);
        chk({tag, "_error"}, error, !exp_done);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_words"}, words_loaded, 64'(exp_words));
        chk({tag, "_ren"}, ren_ext, 0);
        $display("load %s: done=%0b error=%0b words=%0d", tag, done, error, words_loaded);
    endtask

    initial begin
        bq_t img;
        wq_t wq;
        int  nw;

        // Reset state
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // Reference two-word image
        wq  = '{32'h00000013, 32'h00100093};
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        chk("vec_stream_byte2", img[2], 8'h13);
        pulse_start();
        chk("vec_busy", busy, 1);
        chk("vec_cpu_en_low", cpu_enable, 0);
        send(img, 0, img.size(), 0, "vec");
        wait_end("vec", 1'b1, 2);
        chk("vec_addr_hold", addr_ext, BASE + 64'd4);
        chk("vec_wdata_hold", wdata_ext, 32'h00100093);

        // Empty image, restarted from DONE
        wq.delete();
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        pulse_start();
        chk("restart_cpu_en", cpu_enable, 0);
        chk("restart_busy", busy, 1);
        chk("restart_words", words_loaded, 0);
        send(img, 0, img.size(), 0, "empty");
        wait_end("empty", 1'b1, 0);

        // Over-capacity header
        img = '{8'h01, 8'h02};
        pulse_start();
        send(img, 0, img.size(), 0, "big");
        wait_end("big", 1'b0, 0);

        // Recover from ERR with a one-word image
        wq  = rand_words(1);
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        pulse_start();
        chk("recover_error_clr", error, 0);
        chk("recover_busy", busy, 1);
        send(img, 0, img.size(), 2, "recover");
        wait_end("recover", 1'b1, 1);

        // Valid toggling every other cycle
        wq  = rand_words(3);
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        pulse_start();
        send(img, 0, img.size(), 1, "toggle");
        wait_end("toggle", 1'b1, 3);

        // Random sizes and random valid gaps
        for (int it = 0; it < 4; it++) begin
            nw  = $urandom_range(1, 6);
            wq  = rand_words(nw);
            img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
            img = with_trailer(img, wq, 32'd0);
`endif
            pulse_start();
            send(img, 0, img.size(), 2, "rand");
            wait_end("rand", 1'b1, nw);
        end

        // start while busy is ignored mid-word
        wq  = rand_words(2);
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        pulse_start();
        send(img, 0, 5, 0, "busy_start_a");
        pulse_start();
        chk("busy_start_still_busy", busy, 1);
        send(img, 5, img.size(), 0, "busy_start_b");
        wait_end("busy_start", 1'b1, 2);

        // Reset after 2 of 4 words, then a clean reload
        wq  = rand_words(4);
        img = make_image(wq);
`ifdef LOADER_CHECKSUM_EN
        img = with_trailer(img, wq, 32'd0);
`endif
        pulse_start();
        send(img, 0, 10, 0, "midrst");
        chk("midrst_words_before", words_loaded, 1);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        arst_n = 1'b1;
        pulse_start();
        send(img, 0, img.size(), 2, "reload");
        wait_end("reload", 1'b1, 4);

`ifdef LOADER_CHECKSUM_EN
        // Checksum: words 1,2 -> trailer 3 accepted, trailer 4 rejected
        wq  = '{32'd1, 32'd2};
        img = with_trailer(make_image(wq), wq, 32'd0);
        chk("csum_trailer_byte", img[10], 8'h03);
        pulse_start();
        send(img, 0, img.size(), 0, "csum_ok");
        wait_end("csum_ok", 1'b1, 2);
        img = with_trailer(make_image(wq), wq, 32'd1);
        pulse_start();
        send(img, 0, img.size(), 0, "csum_bad");
        wait_end("csum_bad", 1'b0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
